// File: rtl/car_path_replay_pkg.sv
// Shared codes, states and decode helpers for the path-replay car controller.
package car_pkg;

  localparam logic [7:0] C_STOP  = 8'd10;
  localparam logic [7:0] C_FWD   = 8'd11;
  localparam logic [7:0] C_BACK  = 8'd12;
  localparam logic [7:0] C_RFWD  = 8'd13;
  localparam logic [7:0] C_LFWD  = 8'd14;
  localparam logic [7:0] C_LEFT  = 8'd15;
  localparam logic [7:0] C_RIGHT = 8'd16;
  localparam logic [7:0] C_TURN  = 8'd17;
  localparam logic [7:0] C_NTURN = 8'd18;
  localparam logic [7:0] C_CATCH = 8'd19;
  localparam logic [7:0] C_RET   = 8'd20;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RECORD = 3'd1,
    S_TURN   = 3'd2,
    S_FETCH  = 3'd3,
    S_REPLAY = 3'd4,
    S_DONE   = 3'd5
  } state_e;

  function automatic logic [7:0] mirror(
    input logic [7:0] c
  );
    logic [7:0] m;
    m = c;
    case (c)
      C_LFWD:  m = C_RFWD;
      C_RFWD:  m = C_LFWD;
      C_LEFT:  m = C_RIGHT;
      C_RIGHT: m = C_LEFT;
      C_TURN:  m = C_NTURN;
      C_NTURN: m = C_TURN;
      C_CATCH: m = C_STOP;
      default: m = c;
    endcase
    return m;
  endfunction

  // Returns {left[1:0], right[1:0]}.
  function automatic logic [3:0] wheels(
    input logic [7:0] c
  );
    logic [3:0] w;
    case (c)
      C_FWD:           w = 4'b01_01;
      C_BACK:          w = 4'b10_10;
      C_LEFT, C_NTURN: w = 4'b10_01;
      C_RIGHT, C_TURN: w = 4'b01_10;
      C_LFWD:          w = 4'b00_01;
      C_RFWD:          w = 4'b01_00;
      default:         w = 4'b00_00;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/car_path_replay_path_ram.sv
// Run-length path buffer: synchronous write, registered read.
module path_ram #(
  parameter int DEPTH = 256,
  parameter int W     = 20
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [W-1:0]             wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [W-1:0]             rdata_o
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/car_path_replay.sv
// Records drive commands as runs and replays them mirrored in reverse.
// Optional PWM enable gating: define CAR_REPLAY_PWM_EN.
module car_path_replay
  import car_pkg::*;
#(
  parameter int DEPTH      = 256,
  parameter int DUR_W      = 12,
  parameter int TURN_TICKS = 60,
  parameter int PWM_W      = 8,
  parameter int PWM_DUTY   = 192
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clk19,
  input  logic                       start,
  input  logic                       ret,
  input  logic                       abort,
  input  logic [7:0]                 cmd,
  input  logic                       sensor,
  output logic [1:0]                 left,
  output logic [1:0]                 right,
  output logic                       left_Motor,
  output logic                       right_Motor,
  output logic [2:0]                 state,
  output logic [7:0]                 motor_code,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       ovf,
  output logic                       done
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TURN_TICKS + 1);
  localparam logic [AW:0]      FULL = (AW + 1)'(DEPTH);
  localparam logic [DUR_W-1:0] DMAX = '1;
  localparam logic [DUR_W-1:0] DONE1 = DUR_W'(1);
  localparam logic [TW-1:0]    TLAST = TW'(TURN_TICKS - 1);

  state_e            state_q, state_d;
  logic [7:0]        code_q, code_d;
  logic [DUR_W-1:0]  dur_q, dur_d;
  logic [AW:0]       count_q, count_d;
  logic [AW:0]       idx_q, idx_d;
  logic [TW-1:0]     tick_q, tick_d;
  logic              ovf_q, ovf_d;
  logic              phase_q, phase_d;
  logic              paused_q, paused_d;
  logic [7:0]        mc_q, mc_d;
  logic [3:0]        lr_q, lr_d;
  logic              done_q, done_d;
  logic              close, we, pwm_on;
  logic [AW-1:0]     raddr;
  logic [7+DUR_W:0]  rdata;

  assign raddr = idx_q[AW-1:0] - 1'b1;

  path_ram #(.DEPTH(DEPTH), .W(8 + DUR_W)) u_ram (
    .clk_i   (clk),
    .we_i    (we),
    .waddr_i (count_q[AW-1:0]),
    .wdata_i ({code_q, dur_q}),
    .raddr_i (raddr),
    .rdata_o (rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      code_q   <= C_STOP;
      dur_q    <= '0;
      count_q  <= '0;
      idx_q    <= '0;
      tick_q   <= '0;
      ovf_q    <= 1'b0;
      phase_q  <= 1'b0;
      paused_q <= 1'b0;
      mc_q     <= C_STOP;
      lr_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      dur_q    <= dur_d;
      count_q  <= count_d;
      idx_q    <= idx_d;
      tick_q   <= tick_d;
      ovf_q    <= ovf_d;
      phase_q  <= phase_d;
      paused_q <= paused_d;
      mc_q     <= mc_d;
      lr_q     <= lr_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    dur_d    = dur_q;
    count_d  = count_q;
    idx_d    = idx_q;
    tick_d   = tick_q;
    ovf_d    = ovf_q;
    phase_d  = phase_q;
    paused_d = paused_q;
    close    = 1'b0;
    we       = 1'b0;
    if (abort) begin
      state_d  = S_IDLE;
      phase_d  = 1'b0;
      paused_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_d = S_RECORD;
            count_d = '0;
            ovf_d   = 1'b0;
            code_d  = C_STOP;
            dur_d   = '0;
          end
        end
        S_RECORD: begin
          if (ret || (clk19 && cmd == C_RET)) begin
            close   = 1'b1;
            state_d = S_TURN;
            tick_d  = '0;
          end else if (clk19) begin
            if (cmd == code_q && dur_q != DMAX) begin
              dur_d = dur_q + 1'b1;
            end else begin
              close  = 1'b1;
              code_d = cmd;
              dur_d  = DONE1;
            end
          end
        end
        S_TURN: begin
          if (clk19) begin
            if (tick_q == TLAST) begin
              state_d = (count_q != '0) ? S_FETCH : S_DONE;
              idx_d   = count_q;
              phase_d = 1'b0;
            end else begin
              tick_d = tick_q + 1'b1;
            end
          end
        end
        S_FETCH: begin
          // Second cycle: registered read data is valid.
          if (!phase_q) begin
            phase_d = 1'b1;
          end else begin
            code_d   = rdata[7+DUR_W:DUR_W];
            dur_d    = rdata[DUR_W-1:0];
            idx_d    = idx_q - 1'b1;
            phase_d  = 1'b0;
            paused_d = 1'b0;
            state_d  = S_REPLAY;
          end
        end
        S_REPLAY: begin
          if (sensor) begin
            paused_d = 1'b1;
          end else if (clk19) begin
            if (paused_q) begin
              paused_d = 1'b0;
            end else if (dur_q == DONE1) begin
              dur_d   = '0;
              state_d = (idx_q != '0) ? S_FETCH : S_DONE;
            end else begin
              dur_d = dur_q - 1'b1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    if (close && dur_q != '0) begin
      if (count_q < FULL) begin
        we      = 1'b1;
        count_d = count_q + 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_comb begin
    mc_d   = mc_q;
    lr_d   = lr_q;
    done_d = 1'b0;
    unique case (state_d)
      S_RECORD: begin
        if (state_q == S_RECORD && clk19) mc_d = cmd;
        lr_d = wheels(mc_d);
      end
      S_TURN: begin
        mc_d = C_TURN;
        lr_d = wheels(C_TURN);
      end
      S_FETCH: begin
        mc_d = mc_q;
      end
      S_REPLAY: begin
        mc_d = mirror(code_d);
        lr_d = paused_d ? 4'b0 : wheels(mc_d);
      end
      S_DONE: begin
        mc_d   = C_STOP;
        lr_d   = '0;
        done_d = 1'b1;
      end
      default: begin
        mc_d = C_STOP;
        lr_d = '0;
      end
    endcase
  end

`ifdef CAR_REPLAY_PWM_EN
  logic [PWM_W-1:0] pwm_q;

  always_ff @(posedge clk) begin
    if (rst) pwm_q <= '0;
    else     pwm_q <= pwm_q + 1'b1;
  end

  assign pwm_on = {1'b0, pwm_q} < (PWM_W + 1)'(PWM_DUTY);
`else
  // Static enables; PWM settings only sanity-checked here.
  assign pwm_on = (PWM_W >= 0) && (PWM_DUTY >= 0);
`endif

  assign left        = lr_q[3:2];
  assign right       = lr_q[1:0];
  assign left_Motor  = (|lr_q[3:2]) & pwm_on;
  assign right_Motor = (|lr_q[1:0]) & pwm_on;
  assign state       = state_q;
  assign motor_code  = mc_q;
  assign count       = count_q;
  assign ovf         = ovf_q;
  assign done        = done_q;

endmodule
